// File: rtl/pipe_sched_pkg.sv
// Shared types and constants for the pipe spawn scheduler.
// The scheduler's speed-up feature is enabled with PIPE_SCHED_SPEEDUP_EN.
package pipe_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        HOLD
    } sched_state_t;

    // Fibonacci feedback taps: bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
    localparam int          GAP_Y_W           = 9;
    localparam int          SPAWN_COUNT_W     = 16;

endpackage

// File: rtl/pipe_scheduler_if.sv
// Handshake bundle between the game controller, the scheduler and the pipe slots.
// master is the scheduler side; slave is the controller/slot side.
interface pipe_sched_if #(
    parameter int NUM_PIPES = 10
);
    import pipe_sched_pkg::*;

    logic                     clear;
    logic                     run;
    logic [NUM_PIPES-1:0]     pipe_done;
    logic [NUM_PIPES-1:0]     spawn;
    logic [GAP_Y_W-1:0]       gap_y;
    logic [NUM_PIPES-1:0]     active;
    logic                     overflow;
    logic [SPAWN_COUNT_W-1:0] spawn_count;

    modport master (
        input  clear, run, pipe_done,
        output spawn, gap_y, active, overflow, spawn_count
    );

    modport slave (
        output clear, run, pipe_done,
        input  spawn, gap_y, active, overflow, spawn_count
    );

endinterface

// File: rtl/pipe_scheduler_lfsr16.sv
// 16-bit Fibonacci LFSR (shift left, feedback into bit 0) supplying gap heights.
module lfsr16
    import pipe_sched_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] value
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= seed;
        end else if (advance) begin
            value <= {value[14:0], ^(value & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/pipe_scheduler.sv
// Decides when a new pipe enters and which slot takes it, with a random gap height.
// Optional spawn-rate speed-up is compiled in with PIPE_SCHED_SPEEDUP_EN.
module pipe_scheduler
    import pipe_sched_pkg::*;
#(
    parameter int          NUM_PIPES    = 10,
    parameter int          SPAWN_PERIOD = 50_000_000,
    parameter int          FIRST_DELAY  = 25_000_000,
    parameter int          GAP_Y_MIN    = 96,
    parameter logic [15:0] LFSR_SEED    = LFSR_DEFAULT_SEED,
    parameter int          SPEEDUP_STEP = 1_000_000,
    parameter int          MIN_PERIOD   = 20_000_000
) (
    input  logic         clk,
    input  logic         reset_n,
    pipe_sched_if.master bus
);

    localparam int TIMER_MAX = (SPAWN_PERIOD > FIRST_DELAY) ? SPAWN_PERIOD : FIRST_DELAY;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    typedef logic [TIMER_W-1:0]   timer_t;
    typedef logic [NUM_PIPES-1:0] slots_t;

    sched_state_t             state;
    timer_t                   timer;
    timer_t                   reload_val;
    slots_t                   spawn_q;
    slots_t                   active_q;
    logic [GAP_Y_W-1:0]       gap_q;
    logic                     overflow_q;
    logic [SPAWN_COUNT_W-1:0] count_q;
    logic [15:0]              lfsr_value;

    slots_t free_slots;
    slots_t grant;
    logic   tick;
    logic   attempt;
    logic   success;

    // The timer only advances while a run is in progress and run is high;
    // HOLD with run high counts too, so a pause costs exactly its length.
    assign tick       = (state == RUNNING || state == HOLD) && bus.run;
    assign attempt    = tick && (timer == '0) && !bus.clear;
    assign free_slots = ~active_q;
    assign grant      = free_slots & (~free_slots + slots_t'(1));
    assign success    = attempt && (|free_slots);

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .seed    (LFSR_SEED),
        .advance (attempt),
        .value   (lfsr_value)
    );

`ifdef PIPE_SCHED_SPEEDUP_EN
    timer_t     period_q;
    logic [2:0] success_cnt;

    assign reload_val = period_q - timer_t'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q    <= timer_t'(SPAWN_PERIOD);
            success_cnt <= '0;
        end else if (bus.clear) begin
            period_q    <= timer_t'(SPAWN_PERIOD);
            success_cnt <= '0;
        end else if (success) begin
            success_cnt <= success_cnt + 3'd1;
            // Eighth success of a group: shorten the period, floored at MIN_PERIOD.
            if (success_cnt == 3'd7) begin
                if (int'(period_q) >= MIN_PERIOD + SPEEDUP_STEP) begin
                    period_q <= period_q - timer_t'(SPEEDUP_STEP);
                end else begin
                    period_q <= timer_t'(MIN_PERIOD);
                end
            end
        end
    end
`else
    localparam int unused_speedup_cfg = SPEEDUP_STEP + MIN_PERIOD;

    assign reload_val = timer_t'(SPAWN_PERIOD - 1);
`endif

    // NOTE: asynchronous active-low reset sits in the sensitivity list so the
    // outputs drop the instant reset_n falls, without waiting for a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            spawn_q    <= '0;
            gap_q      <= '0;
            active_q   <= '0;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            spawn_q <= '0;
            if (bus.clear) begin
                state      <= IDLE;
                timer      <= '0;
                active_q   <= '0;
                overflow_q <= 1'b0;
            end else begin
                // Slot choice used active_q as it stood before this edge.
                active_q <= (active_q & ~bus.pipe_done) | (success ? grant : '0);

                case (state)
                    IDLE: begin
                        if (bus.run) begin
                            state <= RUNNING;
                            timer <= timer_t'(FIRST_DELAY - 1);
                        end
                    end
                    RUNNING, HOLD: begin
                        if (!bus.run) begin
                            state <= HOLD;
                        end else begin
                            state <= RUNNING;
                            timer <= (timer == '0) ? reload_val : timer - timer_t'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase

                if (success) begin
                    spawn_q <= grant;
                    gap_q   <= GAP_Y_W'(GAP_Y_MIN) + GAP_Y_W'(lfsr_value[7:0]);
                    count_q <= count_q + SPAWN_COUNT_W'(1);
                end else if (attempt) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    assign bus.spawn       = spawn_q;
    assign bus.gap_y       = gap_q;
    assign bus.active      = active_q;
    assign bus.overflow    = overflow_q;
    assign bus.spawn_count = count_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Self-checking bench for pipe_scheduler: directed vector table, async reset,
// optional speed-up intervals, and randomized traffic against a reference model.
module tb_pipe_scheduler;
    import pipe_sched_pkg::*;

    localparam int NP    = 3;
    localparam int SP    = 10;
    localparam int FD    = 5;
    localparam int GMIN  = 96;
    localparam int STEP  = 2;
    localparam int MINP  = 6;
    localparam int SEED  = 'hACE1;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    pipe_sched_if #(.NUM_PIPES(NP)) bus ();

    pipe_scheduler #(
        .NUM_PIPES    (NP),
        .SPAWN_PERIOD (SP),
        .FIRST_DELAY  (FD),
        .GAP_Y_MIN    (GMIN),
        .LFSR_SEED    (16'hACE1),
        .SPEEDUP_STEP (STEP),
        .MIN_PERIOD   (MINP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) checks_passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    task automatic step(input bit r, input bit c, input logic [NP-1:0] d);
        @(negedge clk);
        bus.run       = r;
        bus.clear     = c;
        bus.pipe_done = d;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // A run is either not started, or started (paused whenever run is low).
    bit            m_started;
    int            m_countdown;
    logic [NP-1:0] m_active;
    logic [NP-1:0] m_spawn;
    int            m_gap;
    bit            m_ov;
    int            m_cnt;
    int            m_lfsr;
    int            m_period;
    int            m_succ;

    function automatic int lfsr_next(input int v);
        int fb;
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return ((v << 1) | fb) & 'hFFFF;
    endfunction

    task automatic model_reset();
        m_started = 0; m_countdown = 0; m_active = '0; m_spawn = '0;
        m_gap = 0; m_ov = 0; m_cnt = 0; m_lfsr = SEED; m_period = SP; m_succ = 0;
    endtask

    task automatic model_edge(input bit r, input bit c, input logic [NP-1:0] d);
        int slot;
        slot    = -1;
        m_spawn = '0;
        if (c) begin
            m_started = 0; m_countdown = 0; m_active = '0; m_ov = 0;
            m_period = SP; m_succ = 0;
            return;
        end
        if (!m_started) begin
            if (r) begin
                m_started   = 1;
                m_countdown = FD - 1;
            end
        end else if (r) begin
            if (m_countdown > 0) begin
                m_countdown--;
            end else begin
                for (int i = 0; i < NP; i++) if (!m_active[i] && slot < 0) slot = i;
                m_countdown = m_period - 1;
                if (slot >= 0) begin
                    m_spawn[slot] = 1'b1;
                    m_gap = GMIN + (m_lfsr & 255);
                    m_cnt = (m_cnt + 1) & 'hFFFF;
`ifdef PIPE_SCHED_SPEEDUP_EN
                    m_succ++;
                    if (m_succ % 8 == 0) m_period = (m_period - STEP < MINP) ? MINP : m_period - STEP;
`endif
                end else begin
                    m_ov = 1;
                end
                m_lfsr = lfsr_next(m_lfsr);
            end
        end
        m_active = (m_active & ~d) | m_spawn;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int            cycles;
        bit            run;
        bit            clr;
        logic [NP-1:0] done;
        logic [NP-1:0] spawn;
        int            gap;
        logic [NP-1:0] act;
        bit            ov;
        int            cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int cy, input bit r, input bit c, input logic [NP-1:0] d,
                                input logic [NP-1:0] sp, input int g, input logic [NP-1:0] a,
                                input bit o, input int n);
        vec_t v;
        v.cycles = cy; v.run = r; v.clr = c; v.done = d;
        v.spawn = sp; v.gap = g; v.act = a; v.ov = o; v.cnt = n;
        return v;
    endfunction

    task automatic check_outputs(input string tag, input logic [NP-1:0] sp, input int g,
                                 input logic [NP-1:0] a, input bit o, input int n);
        check({tag, ".spawn"},       int'(bus.spawn),       int'(sp));
        check({tag, ".gap_y"},       int'(bus.gap_y),       g);
        check({tag, ".active"},      int'(bus.active),      int'(a));
        check({tag, ".overflow"},    int'(bus.overflow),    int'(o));
        check({tag, ".spawn_count"}, int'(bus.spawn_count), n);
    endtask

    initial begin
        int spawn_times[$];
        int cyc;

        reset_n       = 1'b0;
        bus.run       = 1'b0;
        bus.clear     = 1'b0;
        bus.pipe_done = '0;
        repeat (2) @(negedge clk);
        check_outputs("reset", 3'b000, 0, 3'b000, 1'b0, 0);
        reset_n = 1'b1;

        // Cycle k is the k-th clock edge after run is first raised.
        vecs.push_back(mk( 6, 1, 0, 3'b000, 3'b001, 321, 3'b001, 0, 1)); // first spawn, gap 96+E1
        vecs.push_back(mk( 1, 1, 0, 3'b000, 3'b000, 321, 3'b001, 0, 1)); // one-cycle pulse, gap held
        vecs.push_back(mk( 9, 1, 0, 3'b000, 3'b010, 291, 3'b011, 0, 2)); // LFSR 59C3
        vecs.push_back(mk(10, 1, 0, 3'b000, 3'b100, 231, 3'b111, 0, 3)); // LFSR B387
        vecs.push_back(mk(10, 1, 0, 3'b000, 3'b000, 231, 3'b111, 1, 3)); // no free slot
        vecs.push_back(mk( 1, 1, 0, 3'b010, 3'b000, 231, 3'b101, 1, 3)); // slot 1 leaves
        vecs.push_back(mk( 1, 1, 0, 3'b010, 3'b000, 231, 3'b101, 1, 3)); // done on inactive slot
        vecs.push_back(mk( 8, 1, 0, 3'b000, 3'b010, 126, 3'b111, 1, 4)); // LFSR CE1E
        vecs.push_back(mk( 2, 1, 0, 3'b000, 3'b000, 126, 3'b111, 1, 4));
        vecs.push_back(mk( 1, 0, 0, 3'b001, 3'b000, 126, 3'b110, 1, 4)); // HOLD, done honoured
        vecs.push_back(mk( 6, 0, 0, 3'b000, 3'b000, 126, 3'b110, 1, 4));
        vecs.push_back(mk( 7, 1, 0, 3'b000, 3'b000, 126, 3'b110, 1, 4)); // not yet: 7-cycle delay
        vecs.push_back(mk( 1, 1, 0, 3'b000, 3'b001, 156, 3'b111, 1, 5)); // LFSR 9C3C
        vecs.push_back(mk( 1, 1, 1, 3'b000, 3'b000, 156, 3'b000, 0, 5)); // clear beats run
        vecs.push_back(mk( 1, 0, 0, 3'b000, 3'b000, 156, 3'b000, 0, 5));
        vecs.push_back(mk( 5, 1, 0, 3'b000, 3'b000, 156, 3'b000, 0, 5));
        vecs.push_back(mk( 1, 1, 0, 3'b000, 3'b001, 217, 3'b001, 0, 6)); // LFSR continued: 3879

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].cycles; k++)
                step(vecs[i].run, vecs[i].clr, (k == 0) ? vecs[i].done : '0);
            check_outputs($sformatf("vec%0d", i), vecs[i].spawn, vecs[i].gap,
                          vecs[i].act, vecs[i].ov, vecs[i].cnt);
        end

        // Asynchronous reset mid-period: outputs drop before any clock edge.
        repeat (3) step(1, 0, '0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_outputs("async_reset", 3'b000, 0, 3'b000, 1'b0, 0);
        @(negedge clk);
        reset_n = 1'b1;

`ifdef PIPE_SCHED_SPEEDUP_EN
        // Slots are released continuously so every attempt succeeds.
        cyc = 0;
        while (spawn_times.size() < 20 && cyc < 400) begin
            step(1, 0, 3'b111);
            cyc++;
            if (bus.spawn != '0) spawn_times.push_back(cyc);
        end
        if (spawn_times.size() < 20) check("speedup.budget", spawn_times.size(), 20);
        else
            for (int i = 0; i < 19; i++)
                check($sformatf("speedup.interval%0d", i), spawn_times[i+1] - spawn_times[i],
                      (i < 8) ? 10 : (i < 16) ? 8 : 6);
        step(0, 1, '0);
`else
        spawn_times.delete();
        cyc = 0;
`endif

        // Randomized traffic against the model.
        @(negedge clk);
        reset_n       = 1'b0;
        bus.run       = 1'b0;
        bus.clear     = 1'b0;
        bus.pipe_done = '0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            bit            r;
            bit            c;
            logic [NP-1:0] d;
            r = ($urandom_range(0, 15) != 0);
            c = ($urandom_range(0, 199) == 0);
            d = NP'($urandom & $urandom & $urandom);
            step(r, c, d);
            model_edge(r, c, d);
            check_outputs($sformatf("rand%0d", n), m_spawn, m_gap, m_active, m_ov, m_cnt);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
